// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants, types and digit helpers for the four-digit multiplexed display scanner.
package display_scan_ctrl_pkg;

   localparam int DIV_DEFAULT          = 50000;
   localparam int DEAD_DEFAULT         = 500;
   localparam int BLINK_FRAMES_DEFAULT = 125;

   localparam logic [3:0] ANODES_OFF = 4'b1111;
   localparam logic [3:0] LAMP_DIGIT = 4'd8;
   localparam int         SLOT_W     = 2;

   typedef logic [SLOT_W-1:0] slot_t;

   typedef struct packed {
      logic [3:0] state;
      logic [2:0] energy;
      logic [2:0] hunger;
      logic [2:0] entertainment;
   } snapshot_t;

   function automatic logic [3:0] digit_value(snapshot_t snap, slot_t slot);
      case (slot)
         2'd0:    return snap.state;
         2'd1:    return {1'b0, snap.energy};
         2'd2:    return {1'b0, snap.hunger};
         default: return {1'b0, snap.entertainment};
      endcase
   endfunction

   function automatic logic [3:0] anode_select(slot_t slot);
      return ~(4'b0001 << slot);
   endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Display data bundle: pet status in, BCD digit / anode drive / frame pulse out.
interface display_scan_ctrl_if;

   logic [3:0] state;
   logic [2:0] energy;
   logic [2:0] hunger;
   logic [2:0] entertainment;
   logic       blank;
   logic       lamp_test;
   logic [3:0] bcd;
   logic [3:0] an;
   logic       frame_tick;

   modport master (
      output state, energy, hunger, entertainment, blank, lamp_test,
      input  bcd, an, frame_tick
   );

   modport slave (
      input  state, energy, hunger, entertainment, blank, lamp_test,
      output bcd, an, frame_tick
   );

endinterface

// File: rtl/display_scan_ctrl_tick_gen.sv
// Free-running modulo-DIV counter with a single-cycle enable in its terminal count.
module tick_gen #(
   parameter int DIV = 4,
   parameter int CW  = $clog2(DIV)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] count,
   output logic          wrap
);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      wrap    = (count_q == CW'(DIV - 1));
      count_d = wrap ? '0 : count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit time-multiplexed display scanner with dead time, frame snapshot,
// zero-digit blinking, lamp test and blanking.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int DIV          = DIV_DEFAULT,
   parameter int DEAD         = DEAD_DEFAULT,
   parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
) (
   input logic                clk,
   input logic                rst,
   display_scan_ctrl_if.slave bus
);

   localparam int CW = $clog2(DIV);
   localparam int FW = $clog2(BLINK_FRAMES + 1);

   logic [CW-1:0] presc;
   logic          wrap;
   logic          frame_start;
   logic [3:0]    digit;

   slot_t         slot_q, slot_d;
   snapshot_t     snap_q, snap_d;
   logic          phase_q, phase_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic [3:0]    bcd_q, bcd_d;
   logic [3:0]    an_q, an_d;
   logic          frame_tick_q, frame_tick_d;

   tick_gen #(.DIV(DIV), .CW(CW)) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .count (presc),
      .wrap  (wrap)
   );

   always_comb begin
      frame_start  = wrap && (slot_q == slot_t'(3));
      slot_d       = wrap ? slot_q + 1'b1 : slot_q;
      snap_d       = snap_q;
      phase_d      = phase_q;
      frame_cnt_d  = frame_cnt_q;
      frame_tick_d = frame_start;
      if (frame_start) begin
         snap_d.state         = bus.state;
         snap_d.energy        = bus.energy;
         snap_d.hunger        = bus.hunger;
         snap_d.entertainment = bus.entertainment;
         if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   // Lamp test overrides blank and blink but still honours the dead time.
   always_comb begin
      digit = digit_value(snap_q, slot_q);
      bcd_d = bus.lamp_test ? LAMP_DIGIT : digit;
      an_d  = anode_select(slot_q);
      if (presc < CW'(DEAD)) begin
         an_d = ANODES_OFF;
      end else if (!bus.lamp_test &&
                   (bus.blank || (phase_q && (slot_q != '0) && (digit == 4'd0)))) begin
         an_d = ANODES_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q       <= '0;
         snap_q       <= '0;
         phase_q      <= 1'b0;
         frame_cnt_q  <= '0;
         bcd_q        <= '0;
         an_q         <= ANODES_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         slot_q       <= slot_d;
         snap_q       <= snap_d;
         phase_q      <= phase_d;
         frame_cnt_q  <= frame_cnt_d;
         bcd_q        <= bcd_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign bus.bcd        = bcd_q;
   assign bus.an         = an_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DIV, default 50000, clocks per digit slot (min 4).
REQ-002 Parameter DEAD, default 500, clocks of all-anodes-off at start of each slot (must be < DIV).
REQ-003 Parameter BLINK_FRAMES, default 125, frames per blink half-period (min 1).
REQ-004 clk  input  1  system clock; sole clock domain.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 state  input  4  pet state code from central FSM, shown on digit 0.
REQ-007 energy  input  3  energy level, shown on digit 1 as {1'b0,energy}.
REQ-008 hunger  input  3  hunger level, shown on digit 2 as {1'b0,hunger}.
REQ-009 entertainment  input  3  entertainment level, shown on digit 3 as {1'b0,entertainment}.
REQ-010 blank  input  1  level; when high, all anodes off.
REQ-011 lamp_test  input  1  level; when high, every digit shows 4'd8, no blink.
REQ-012 bcd  output  4  digit value to the BCD-to-seven-segment decoder.
REQ-013 an  output  4  anode enables, active-low, an[i] selects digit i.
REQ-014 frame_tick  output  1  one-cycle pulse at each frame start.

Function
REQ-015 Prescaler counts 0..DIV-1 and wraps; at wrap, slot index advances 0->1->2->3->0.
REQ-016 Frame = 4 slots = 4*DIV clocks; frame start = cycle where prescaler wraps and slot goes 3->0.
REQ-017 At frame start, state/energy/hunger/entertainment are captured into a snapshot; bcd is always driven from the snapshot, so input changes mid-frame appear only from next frame.
REQ-018 frame_tick high exactly one cycle, in the cycle the snapshot is loaded.
REQ-019 bcd and an are registered; they reflect prescaler/slot values of the previous cycle (1-cycle latency).
REQ-020 For prescaler < DEAD, an = 4'b1111; otherwise an = ~(4'b0001 << slot), subject to REQ-021..023.
REQ-021 Blink phase toggles every BLINK_FRAMES frames; phase 0 = visible. A digit 1..3 whose snapshot value is 0 has its anode forced off during phase 1; digit 0 never blinks.
REQ-022 lamp_test has priority over blank and blink: bcd = 4'd8, anodes follow REQ-020 only.
REQ-023 blank (with lamp_test low) forces an = 4'b1111; bcd continues to follow the snapshot; counters keep running.
REQ-024 blank/lamp_test are sampled every cycle (not snapshotted); effect visible next cycle.
REQ-025 Never more than one an bit low in any cycle.

Reset
REQ-026 While rst high at a clock edge: prescaler = 0, slot = 0, snapshot = 0, blink phase = 0, frame frame counter = 0.
REQ-027 Outputs after reset edge: an = 4'b1111, bcd = 4'd0, frame_tick = 0.
REQ-028 Reset mid-frame aborts the frame; first frame_tick occurs 4*DIV clocks after rst deasserts (first snapshot then taken).

Structure
REQ-029 Shared package holds DIV/DEAD/BLINK_FRAMES defaults, ANODES_OFF = 4'b1111, LAMP_DIGIT = 4'd8, slot index width (2 bits).
REQ-030 One sub-module, tick_gen: parameterised modulo-DIV counter emitting a one-cycle wrap enable and its count value; all other logic in display_scan_ctrl.
REQ-031 No derived clocks; all sequencing uses clock enables on clk.

Verification (DIV=4, DEAD=1, BLINK_FRAMES=2)
REQ-032 Reset then run 32 clocks with state=5, energy=3, hunger=2, entertainment=4 -> from cycle 17 on, an cycles 1110,1101,1011,0111 (each 3 clocks after 1 clock of 1111), bcd = 5,3,2,4 respectively.
REQ-033 Change hunger 2->6 mid-frame (slot 1) -> digit 2 still shows 2 in that frame, 6 in next frame; frame_tick single pulse each 16 clocks.
REQ-034 energy=0 -> digit 1 anode low in frames with phase 0, held 1111 in its slot for 2 frames of phase 1, alternating every 2 frames; digit 0 unaffected.
REQ-035 Assert lamp_test and blank together with energy=0 -> bcd=8 in all slots, anodes scan normally, no blinking; drop lamp_test -> an = 1111 next cycle.
REQ-036 Assert rst for 1 cycle in slot 2 -> next cycle an=1111, bcd=0; scan restarts at slot 0; frame_tick 16 clocks after rst low.
REQ-037 Assertion throughout all tests: $countones(~an) <= 1.
